binary_pp_sequencer: RTL and testbench



---
 rtl/binary_pp_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_binary_pp_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_pp_sequencer.sv
// binary_pp_sequencer -- sequential shift-add multiplier controller.
//
// A single binary_pp partial-product generator is time-shared across all
// multiplier bits. The unsigned x*y job is accepted through a valid/ready
// handshake. One (y, x[k]) pair is issued per cycle, LSB first. The returned
// partial products are shifted by k and accumulated into a 2W-bit sum. The
// product is held behind a valid/ready output until the consumer takes it.
//
// Latency, counting the accept edge as edge 0:
//   - ISSUE occupies cycles 1..n.
//   - DRAIN occupies cycles n+1..n+PP_PIPE.
//   - out_valid rises in cycle n+PP_PIPE+1.
// n is always W unless the build defines SEQ_MUL_EARLY_EXIT_EN. With that
// macro, n = msb(x)+1, so issuing stops after the highest set bit of x.
// If x==0, n = 0. Product values are the same in both builds.
//
// Parameters:
//   W        operand width (>= 2)
//   PP_PIPE  pipeline depth of the binary_pp instance (0 = combinational)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   job request            in_ready   sequencer can accept a job
//   x          multiplier (W)         y          multiplicand (W)
//   out_valid  product available      out_ready  consumer accepts product
//   product    unsigned x*y (2W)      busy       controller not idle

// binary_pp -- one row of a binary partial-product array: pp = x_bit ? y : 0,
// optionally registered through PIPE stages.
module binary_pp #(
    parameter int W    = 8,
    parameter int PIPE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] y,
    input  logic         x_bit,
    output logic [W-1:0] pp
);
    logic [W-1:0] pp_comb;

    assign pp_comb = x_bit ? y : '0;

    generate
        if (PIPE == 0) begin : g_comb
            // The combinational variant has no state; clk and rst are unused.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign pp = pp_comb;
        end else begin : g_pipe
            logic [W-1:0] stage [PIPE];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= pp_comb;
                    for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
                end
            end

            assign pp = stage[PIPE-1];
        end
    endgenerate
endmodule

module binary_pp_sequencer #(
    parameter int W       = 8,
    parameter int PP_PIPE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int KW = $clog2(W);
    localparam int DW = (PP_PIPE > 1) ? $clog2(PP_PIPE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    // State entered once the last bit has been issued.
    localparam logic [1:0] S_AFTER_ISSUE = (PP_PIPE > 0) ? S_DRAIN : S_DONE;

    logic [1:0]     state;
    logic [W-1:0]   x_reg;
    logic [W-1:0]   y_reg;
    logic [KW-1:0]  bit_cnt;
    logic [KW-1:0]  last_idx;
    logic [DW-1:0]  drain_cnt;
    logic [2*W-1:0] acc;

    logic           accept;
    logic           accept_zero;
    logic [KW-1:0]  accept_last;
    logic           issue_valid;
    logic [W-1:0]   pp;
    logic           pp_valid;
    logic [KW-1:0]  pp_k;

    assign accept      = (state == S_IDLE) && in_valid;
    assign issue_valid = (state == S_ISSUE);

    // Decide at accept time which bit index ends the ISSUE phase.
`ifdef SEQ_MUL_EARLY_EXIT_EN
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        accept_last = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) accept_last = KW'(i);
        end
    end
    assign accept_zero = ~|x;
`else
    assign accept_last = KW'(W - 1);
    assign accept_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge regardless of order.
        if (rst) begin
            state     <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            bit_cnt   <= '0;
            last_idx  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x;
                        y_reg     <= y;
                        bit_cnt   <= '0;
                        drain_cnt <= '0;
                        last_idx  <= accept_last;
                        // A zero multiplier has no bits to issue.
                        state     <= accept_zero ? S_AFTER_ISSUE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bit_cnt == last_idx) state <= S_AFTER_ISSUE;
                    else                     bit_cnt <= bit_cnt + 1'b1;
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(PP_PIPE - 1)) state <= S_DONE;
                    else                               drain_cnt <= drain_cnt + 1'b1;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    binary_pp #(
        .W    (W),
        .PIPE (PP_PIPE)
    ) u_pp (
        .clk   (clk),
        .rst   (rst),
        .y     (y_reg),
        .x_bit (x_reg[bit_cnt]),
        .pp    (pp)
    );

    // Issue-valid and bit-index tags travel alongside the generator pipeline.
    generate
        if (PP_PIPE == 0) begin : g_tag_comb
            assign pp_valid = issue_valid;
            assign pp_k     = bit_cnt;
        end else begin : g_tag_pipe
            logic          tag_valid [PP_PIPE];
            logic [KW-1:0] tag_k     [PP_PIPE];

            always_ff @(posedge clk) begin
                if (rst) begin
                    // NOTE: the tags must be reset. Clearing them keeps the
                    // stale PPs of a discarded job out of the accumulator.
                    for (int i = 0; i < PP_PIPE; i++) begin
                        tag_valid[i] <= 1'b0;
                        tag_k[i]     <= '0;
                    end
                end else begin
                    tag_valid[0] <= issue_valid;
                    tag_k[0]     <= bit_cnt;
                    for (int i = 1; i < PP_PIPE; i++) begin
                        tag_valid[i] <= tag_valid[i-1];
                        tag_k[i]     <= tag_k[i-1];
                    end
                end
            end

            assign pp_valid = tag_valid[PP_PIPE-1];
            assign pp_k     = tag_k[PP_PIPE-1];
        end
    endgenerate

    // The sum of (pp << k) over all k is at most (2^W-1)^2, so it fits in 2W bits.
    always_ff @(posedge clk) begin
        if (rst)           acc <= '0;
        else if (accept)   acc <= '0;
        else if (pp_valid) acc <= acc + ({{W{1'b0}}, pp} << pp_k);
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign product   = acc;
endmodule

// File: tb/tb_binary_pp_sequencer.sv
// Self-checking bench for binary_pp_sequencer.
// Two instances run side by side: index 0 has PP_PIPE=0 and index 1 has
// PP_PIPE=2. Expected products and latencies come from plain arithmetic on
// the operands.
module tb_binary_pp_sequencer;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst       [2];
    logic           in_valid  [2];
    logic           in_ready  [2];
    logic [W-1:0]   x         [2];
    logic [W-1:0]   y         [2];
    logic           out_valid [2];
    logic           out_ready [2];
    logic [2*W-1:0] product   [2];
    logic           busy      [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    binary_pp_sequencer #(.W(W), .PP_PIPE(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .x         (x[0]),
        .y         (y[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .product   (product[0]),
        .busy      (busy[0])
    );

    binary_pp_sequencer #(.W(W), .PP_PIPE(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .x         (x[1]),
        .y         (y[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .product   (product[1]),
        .busy      (busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Number of multiplier bits the controller is expected to issue.
    function automatic int ref_bits(input logic [W-1:0] v);
        int n;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    function automatic int pipe_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Run one job on instance d. The task is entered and left at a negedge
    // with the instance idle. hold = number of DONE cycles with out_ready low.
    // poke = pulse a foreign in_valid during the hold.
    task automatic run_job(input int d, input logic [W-1:0] xv, input logic [W-1:0] yv,
                           input int hold, input bit poke);
        int             cyc;
        int             exp_lat;
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        logic [2*W-1:0] exp_p;
        a       = {{W{1'b0}}, xv};
        b       = {{W{1'b0}}, yv};
        exp_p   = a * b;
        exp_lat = ref_bits(xv) + pipe_of(d) + 1;

        chk($sformatf("d%0d in_ready_before_job", d), in_ready[d], 1);
        in_valid[d] = 1'b1;
        x[d] = xv;
        y[d] = yv;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        in_valid[d] = 1'b0;
        // Scramble the operands; the controller must not resample them.
        x[d] = W'($urandom);
        y[d] = W'($urandom);
        chk($sformatf("d%0d in_ready_busy", d), in_ready[d], 0);
        chk($sformatf("d%0d busy_flag", d), busy[d], 1);

        while (!out_valid[d] && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("d%0d latency x=%0h", d, xv), cyc, exp_lat);
        chk($sformatf("d%0d product %0h*%0h", d, xv, yv), product[d], exp_p);

        for (int h = 0; h < hold; h++) begin
            out_ready[d] = 1'b0;
            if (poke && h == 1) begin
                in_valid[d] = 1'b1;
                x[d] = 8'h77;
                y[d] = 8'h99;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid[d] = 1'b0;
            chk($sformatf("d%0d hold_out_valid", d), out_valid[d], 1);
            chk($sformatf("d%0d hold_product", d), product[d], exp_p);
            chk($sformatf("d%0d hold_in_ready", d), in_ready[d], 0);
        end

        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk($sformatf("d%0d released_out_valid", d), out_valid[d], 0);
        chk($sformatf("d%0d released_in_ready", d), in_ready[d], 1);
    endtask

    // Start an 0xAA*0x55 job and assert rst in cycle 4.
    task automatic reset_mid(input int d);
        in_valid[d] = 1'b1;
        x[d] = 8'hAA;
        y[d] = 8'h55;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
        chk($sformatf("d%0d rst_in_ready", d), in_ready[d], 1);
        chk($sformatf("d%0d rst_out_valid", d), out_valid[d], 0);
        chk($sformatf("d%0d rst_product", d), product[d], 0);
        chk($sformatf("d%0d rst_busy", d), busy[d], 0);
    endtask

    initial begin
        logic [W-1:0] xv;
        logic [W-1:0] yv;

        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            x[d]         = '0;
            y[d]         = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            chk($sformatf("d%0d reset_in_ready", d), in_ready[d], 1);
            chk($sformatf("d%0d reset_out_valid", d), out_valid[d], 0);
            chk($sformatf("d%0d reset_busy", d), busy[d], 0);
            chk($sformatf("d%0d reset_product", d), product[d], 0);
        end

        // All-ones operands.
        run_job(0, 8'hFF, 8'hFF, 0, 1'b0);
        run_job(1, 8'hFF, 8'hFF, 0, 1'b0);
        // Pipelined generator with a short multiplier.
        run_job(1, 8'h0D, 8'h0B, 0, 1'b0);
        run_job(0, 8'h0D, 8'h0B, 0, 1'b0);
        // Backpressure with an ignored request during the hold.
        run_job(0, 8'h12, 8'h34, 5, 1'b1);
        run_job(1, 8'h12, 8'h34, 5, 1'b1);
        // Reset mid-job, then a clean follow-up job.
        reset_mid(0);
        run_job(0, 8'h03, 8'h05, 0, 1'b0);
        reset_mid(1);
        run_job(1, 8'h03, 8'h05, 0, 1'b0);
        // Zero operands.
        run_job(0, 8'h00, 8'hAB, 0, 1'b0);
        run_job(1, 8'h00, 8'hAB, 0, 1'b0);
        run_job(0, 8'h80, 8'h00, 0, 1'b0);
        // Random back-to-back stream.
        for (int i = 0; i < 400; i++) begin
            xv = W'($urandom);
            yv = W'($urandom);
            if ($urandom_range(0, 7) == 0) xv = '0;
            if ($urandom_range(0, 7) == 0) yv = '0;
            run_job(i % 2, xv, yv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
